y86_stage_sequencer: RTL and testbench
======================================

# y86_stage_sequencer

Multi-cycle controller for the sequential Y86-64 core. It steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update by asserting one stage enable per cycle, and stalls in the memory stage until data memory acknowledges. It tracks the processor status code (AOK/HLT/ADR/INS) and stops the core on halt or error. Retired-instruction and active-cycle counters are kept for the testbench and performance reporting.

## Interface
- CNT_W, 32, width of instr_count and cycle_count
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin execution; sampled only in IDLE
- icode  input  4  instruction code from fetch; valid while fetch_en=1
- instr_valid  input  1  fetch decoded a legal icode/ifun; valid while fetch_en=1
- imem_error  input  1  instruction address out of range; valid while fetch_en=1
- mem_ready  input  1  data memory done; sampled only in MEM for memory-class icodes
- dmem_error  input  1  data address out of range; sampled together with mem_ready
- fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en  output  1 each  stage enables, at most one high per cycle
- busy  output  1  state is neither IDLE nor HALTED
- halted  output  1  state is HALTED
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- instr_count  output  CNT_W  instructions retired, including halt
- cycle_count  output  CNT_W  cycles with busy=1

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, HALTED. Enables are decoded from the state register (Moore), one-hot: FETCH→fetch_en, DECODE→decode_en, EXEC→execute_en, MEM→memory_en, WB→writeback_en, PCUPD→pc_en. All enables are 0 in IDLE and HALTED.
- IDLE: start=1 → FETCH. Otherwise stay.
- FETCH: latch icode into icode_q. Priority order:
  - imem_error=1 → HALTED, stat=ADR.
  - else instr_valid=0 → HALTED, stat=INS.
  - else icode=0 (halt) → HALTED, stat=HLT, instr_count+1. pc_en is never asserted for a halt.
  - else → DECODE.
- DECODE → EXEC → MEM unconditionally, one cycle each.
- MEM: memory-class icode_q is 4,5,8,9,A,B.
  - For memory-class, stay in MEM while mem_ready=0. When mem_ready=1: dmem_error=1 → HALTED, stat=ADR, with no WB, no pc_en and no count; dmem_error=0 → WB.
  - For all other icodes: one cycle → WB. mem_ready and dmem_error are ignored.
- WB → PCUPD. PCUPD: instr_count+1, then → FETCH.
- HALTED: absorbing. Only rst leaves it. start is ignored.
- cycle_count increments on every clock where busy=1, including MEM stall cycles and the final cycle before entering HALTED. Both counters wrap modulo 2^CNT_W.
- stat holds AOK while running and is written only on the transition into HALTED.

## Timing
- Reset values: state=IDLE, all enables 0, busy=0, halted=0, stat=1 (AOK), instr_count=0, cycle_count=0.
- rst=1 in any state, including mid-instruction or during a MEM stall, gives the reset values on the next edge. rst overrides start.
- start sampled high at edge N → fetch_en=1 in cycle N+1.
- Non-memory instruction: 6 cycles (F,D,E,M,W,PC). Memory instruction: 6 + k cycles, where k is the number of MEM cycles sampled with mem_ready=0.
- Back-to-back instructions: fetch_en for the next instruction is high in the cycle immediately after pc_en.
- halted and stat update in the same edge as the transition into HALTED.
- A mem_ready pulse outside MEM, or for a non-memory icode, has no effect.

## Test plan
- Reset then start; stream nop (icode 1) ×3, then halt → enables sequence F,D,E,M,W,PC three times, then one FETCH. Final values: stat=2, halted=1, instr_count=4, cycle_count=19.
- mrmovq (icode 5) with mem_ready low for 3 MEM cycles → memory_en high for 4 cycles, instruction takes 9 cycles, instr_count=1 after pc_en.
- rmmovq (icode 4) with mem_ready=1 and dmem_error=1 → HALTED after MEM, stat=3, writeback_en and pc_en never asserted, instr_count unchanged.
- imem_error=1 and instr_valid=0 in the same FETCH cycle → stat=3 (ADR wins). Separately, instr_valid=0 alone → stat=4.
- Assert rst during a MEM stall of a call (icode 8) → next cycle all outputs at reset values. A later start resumes from FETCH with counters at 0.
- Pulse start in HALTED and mem_ready during EXEC → no state change and no extra enables.

Source files
------------

// File: rtl/y86_stage_sequencer_if.sv
// rtl/y86_stage_sequencer_if.sv - core-side handshake bundle for the Y86-64 stage sequencer
interface y86_stage_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [3:0]       icode;
  logic             instr_valid;
  logic             imem_error;
  logic             mem_ready;
  logic             dmem_error;
  logic             fetch_en;
  logic             decode_en;
  logic             execute_en;
  logic             memory_en;
  logic             writeback_en;
  logic             pc_en;
  logic             busy;
  logic             halted;
  logic [2:0]       stat;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, icode, instr_valid, imem_error, mem_ready, dmem_error,
    input  fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en,
    input  busy, halted, stat, instr_count, cycle_count
  );

  modport slave (
    input  start, icode, instr_valid, imem_error, mem_ready, dmem_error,
    output fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en,
    output busy, halted, stat, instr_count, cycle_count
  );
endinterface

// File: rtl/y86_stage_sequencer.sv
// rtl/y86_stage_sequencer.sv - multi-cycle F/D/E/M/W/PC controller for the sequential Y86-64 core
module y86_stage_sequencer #(
  parameter int CNT_W = 32
) (
  input logic                   clk,
  input logic                   rst,
  y86_stage_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUPD, S_HALTED
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_t           state_q, state_d;
  logic [3:0]       icode_q;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] instr_q, cycle_q;
  logic             instr_inc;
  logic             mem_class;
  logic             busy;

  // mrmovq, rmmovq, call, ret, pushq, popq touch data memory
  always_comb begin
    mem_class = 1'b0;
    case (icode_q)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: mem_class = 1'b1;
      default:                            mem_class = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    instr_inc = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.imem_error) begin
          state_d = S_HALTED;
          stat_d  = STAT_ADR;
        end else if (!bus.instr_valid) begin
          state_d = S_HALTED;
          stat_d  = STAT_INS;
        end else if (bus.icode == 4'h0) begin
          state_d   = S_HALTED;
          stat_d    = STAT_HLT;
          instr_inc = 1'b1;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_MEM;
      S_MEM: begin
        if (!mem_class) begin
          state_d = S_WB;
        end else if (bus.mem_ready) begin
          if (bus.dmem_error) begin
            state_d = S_HALTED;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: state_d = S_PCUPD;
      S_PCUPD: begin
        state_d   = S_FETCH;
        instr_inc = 1'b1;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      icode_q <= 4'h0;
      stat_q  <= STAT_AOK;
      instr_q <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      if (state_q == S_FETCH) icode_q <= bus.icode;
      if (instr_inc)          instr_q <= instr_q + CNT_W'(1);
      if (busy)               cycle_q <= cycle_q + CNT_W'(1);
    end
  end

  assign bus.fetch_en     = (state_q == S_FETCH);
  assign bus.decode_en    = (state_q == S_DECODE);
  assign bus.execute_en   = (state_q == S_EXEC);
  assign bus.memory_en    = (state_q == S_MEM);
  assign bus.writeback_en = (state_q == S_WB);
  assign bus.pc_en        = (state_q == S_PCUPD);
  assign bus.busy         = busy;
  assign bus.halted       = (state_q == S_HALTED);
  assign bus.stat         = stat_q;
  assign bus.instr_count  = instr_q;
  assign bus.cycle_count  = cycle_q;
endmodule

// File: tb/tb_y86_stage_sequencer.sv
// tb/tb_y86_stage_sequencer.sv - directed bench for the Y86-64 stage sequencer
module tb_y86_stage_sequencer;
  localparam int CNT_W = 32;
  localparam logic [5:0] EN_N = 6'b000000;
  localparam logic [5:0] EN_F = 6'b100000;
  localparam logic [5:0] EN_D = 6'b010000;
  localparam logic [5:0] EN_E = 6'b001000;
  localparam logic [5:0] EN_M = 6'b000100;
  localparam logic [5:0] EN_W = 6'b000010;
  localparam logic [5:0] EN_P = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  y86_stage_sequencer_if #(.CNT_W(CNT_W)) bus ();

  y86_stage_sequencer #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [5:0] en;
  assign en = {bus.fetch_en, bus.decode_en, bus.execute_en,
               bus.memory_en, bus.writeback_en, bus.pc_en};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // check stage enables in the current cycle, then advance one cycle
  task automatic cyc(input string tag, input logic [5:0] exp);
    chk(tag, {58'd0, en}, {58'd0, exp});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.icode = 4'h1;
    bus.instr_valid = 1'b1;
    bus.imem_error = 1'b0;
    bus.mem_ready = 1'b0;
    bus.dmem_error = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"},     {58'd0, en}, 64'd0);
    chk({tag, "_busy"},   {63'd0, bus.busy}, 64'd0);
    chk({tag, "_halted"}, {63'd0, bus.halted}, 64'd0);
    chk({tag, "_stat"},   {61'd0, bus.stat}, 64'd1);
    chk({tag, "_icnt"},   {32'd0, bus.instr_count}, 64'd0);
    chk({tag, "_ccnt"},   {32'd0, bus.cycle_count}, 64'd0);
  endtask

  initial begin
    // nop x3 then halt
    do_reset();
    chk_reset_vals("rst");
    do_start();
    for (int i = 0; i < 3; i++) begin
      cyc("nop_f", EN_F); cyc("nop_d", EN_D); cyc("nop_e", EN_E);
      cyc("nop_m", EN_M); cyc("nop_w", EN_W); cyc("nop_p", EN_P);
    end
    bus.icode = 4'h0;
    cyc("hlt_f", EN_F);
    chk("hlt_en", {58'd0, en}, 64'd0);
    chk("hlt_halted", {63'd0, bus.halted}, 64'd1);
    chk("hlt_busy", {63'd0, bus.busy}, 64'd0);
    chk("hlt_stat", {61'd0, bus.stat}, 64'd2);
    chk("hlt_icnt", {32'd0, bus.instr_count}, 64'd4);
    chk("hlt_ccnt", {32'd0, bus.cycle_count}, 64'd19);

    // start pulse while halted is ignored
    do_start();
    @(negedge clk);
    chk("hstart_en", {58'd0, en}, 64'd0);
    chk("hstart_halted", {63'd0, bus.halted}, 64'd1);
    chk("hstart_ccnt", {32'd0, bus.cycle_count}, 64'd19);

    // mrmovq with three stall cycles
    do_reset();
    do_start();
    bus.icode = 4'h5;
    cyc("mr_f", EN_F); cyc("mr_d", EN_D); cyc("mr_e", EN_E);
    for (int i = 0; i < 3; i++) cyc("mr_stall", EN_M);
    bus.mem_ready = 1'b1;
    cyc("mr_m", EN_M);
    bus.mem_ready = 1'b0;
    cyc("mr_w", EN_W);
    chk("mr_icnt_pre", {32'd0, bus.instr_count}, 64'd0);
    cyc("mr_p", EN_P);
    chk("mr_next_f", {58'd0, en}, {58'd0, EN_F});
    chk("mr_icnt", {32'd0, bus.instr_count}, 64'd1);
    chk("mr_ccnt", {32'd0, bus.cycle_count}, 64'd9);

    // rmmovq with data address error
    do_reset();
    do_start();
    bus.icode = 4'h4;
    cyc("rm_f", EN_F); cyc("rm_d", EN_D); cyc("rm_e", EN_E);
    bus.mem_ready = 1'b1;
    bus.dmem_error = 1'b1;
    cyc("rm_m", EN_M);
    bus.mem_ready = 1'b0;
    bus.dmem_error = 1'b0;
    chk("rm_halted", {63'd0, bus.halted}, 64'd1);
    chk("rm_stat", {61'd0, bus.stat}, 64'd3);
    chk("rm_icnt", {32'd0, bus.instr_count}, 64'd0);
    chk("rm_ccnt", {32'd0, bus.cycle_count}, 64'd4);
    cyc("rm_after0", EN_N);
    cyc("rm_after1", EN_N);

    // imem_error and invalid instruction together: ADR wins
    do_reset();
    do_start();
    bus.imem_error = 1'b1;
    bus.instr_valid = 1'b0;
    cyc("adr_f", EN_F);
    chk("adr_stat", {61'd0, bus.stat}, 64'd3);
    chk("adr_icnt", {32'd0, bus.instr_count}, 64'd0);
    chk("adr_ccnt", {32'd0, bus.cycle_count}, 64'd1);

    // invalid instruction alone
    do_reset();
    do_start();
    bus.instr_valid = 1'b0;
    cyc("ins_f", EN_F);
    chk("ins_stat", {61'd0, bus.stat}, 64'd4);
    chk("ins_halted", {63'd0, bus.halted}, 64'd1);

    // reset during a call stall, then restart
    do_reset();
    do_start();
    bus.icode = 4'h8;
    cyc("call_f", EN_F); cyc("call_d", EN_D); cyc("call_e", EN_E);
    cyc("call_m0", EN_M); cyc("call_m1", EN_M);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    chk_reset_vals("mrst");
    do_start();
    chk("mrst_f", {58'd0, en}, {58'd0, EN_F});
    chk("mrst_icnt", {32'd0, bus.instr_count}, 64'd0);
    chk("mrst_ccnt", {32'd0, bus.cycle_count}, 64'd0);

    // mem_ready pulse in EXEC must not skip the MEM stall
    do_reset();
    do_start();
    bus.icode = 4'h5;
    cyc("ex_f", EN_F); cyc("ex_d", EN_D);
    bus.mem_ready = 1'b1;
    cyc("ex_e", EN_E);
    bus.mem_ready = 1'b0;
    cyc("ex_m0", EN_M);
    cyc("ex_m1", EN_M);
    bus.mem_ready = 1'b1;
    cyc("ex_m2", EN_M);
    bus.mem_ready = 1'b0;
    cyc("ex_w", EN_W);
    cyc("ex_p", EN_P);
    chk("ex_icnt", {32'd0, bus.instr_count}, 64'd1);
    chk("ex_ccnt", {32'd0, bus.cycle_count}, 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
